// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default geometry, the hardwired
// zero-register index and the write-counter saturation limit.
package reg_file_pkg;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned WCNT_W     = 8;

    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = 5'd0;
    localparam logic [WCNT_W-1:0]     WCNT_MAX = 8'd255;
endpackage : reg_file_pkg

// File: rtl/reg_read_port.sv
// One combinational read port: storage mux, zero-register force and
// write-first forwarding of the in-flight write data.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic                    rst,
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [ADDR_W-1:0]       ra,
    output logic [DATA_W-1:0]       rd
);

    logic             ra_zero_s;
    logic             bypass_s;
    logic [DATA_W-1:0] stored_s;

    assign ra_zero_s = (ra == ADDR_W'(ZERO_REG));
    assign bypass_s  = we && !rst && (wa != ADDR_W'(ZERO_REG)) && (ra == wa);
    assign stored_s  = mem_flat[int'(ra)*DATA_W +: DATA_W];

    // Select read data; reset and the zero register take priority over forwarding.
    always_comb begin
        rd = '0;
        if (rst || ra_zero_s) begin
            rd = '0;
        end else if (bypass_s) begin
            rd = wd;
        end else begin
            rd = stored_s;
        end
    end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// 2-read/1-write register file with a hardwired zero entry, write-first
// forwarding and a saturating count of committed writes.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [7:0]        WCNT
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Entry 0 has no storage at all; it reads as zero through the flat bus.
    logic [DATA_W-1:0]       mem_q [1:DEPTH-1];
    logic [DATA_W-1:0]       mem_d [1:DEPTH-1];
    logic [7:0]              wcnt_q;
    logic [7:0]              wcnt_d;
    logic                    commit_s;
    logic [DEPTH*DATA_W-1:0] mem_flat_s;

    assign commit_s = WE && (WA != ADDR_W'(ZERO_REG));

    // Next-state for storage and the saturating write counter.
    always_comb begin
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (commit_s && (WA == ADDR_W'(i))) begin
                mem_d[i] = WD;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        if (commit_s && (wcnt_q != WCNT_MAX)) begin
            wcnt_d = wcnt_q + 8'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q  <= '{default: '0};
            wcnt_q <= 8'd0;
        end else begin
            mem_q  <= mem_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Flatten storage for the read ports, with a constant-zero slot 0.
    always_comb begin
        mem_flat_s = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            mem_flat_s[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd1 (
        .rst      (RST),
        .mem_flat (mem_flat_s),
        .we       (WE),
        .wa       (WA),
        .wd       (WD),
        .ra       (RA1),
        .rd       (RD1)
    );

    reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd2 (
        .rst      (RST),
        .mem_flat (mem_flat_s),
        .we       (WE),
        .wa       (WA),
        .wd       (WD),
        .ra       (RA2),
        .rd       (RD2)
    );

    assign WCNT = wcnt_q;

endmodule : reg_file
